// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch squashes, multicycle waits, plus saturating perf counters.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   id_rs, id_rt, id_uses_rt operands of the instruction in ID
//   ex_mem_read, ex_rd       load in EX and its destination
//   ex_branch_taken          branch in EX resolved taken
//   mc_start, mc_done        multicycle op issue / completion
//   pc_write, if_id_write    PC and IF/ID capture enables
//   if_id_flush              IF/ID loads NOP
//   id_ex_bubble             ID/EX loads NOP controls
//   stall_count, flush_count saturating perf counters
//   state                    RUN=0, MC_WAIT=1, FLUSH=2
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mc_start,
    input  logic             mc_done,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    localparam int RW = (FLUSH_SLOTS > 1) ? $clog2(FLUSH_SLOTS) : 1;
    localparam logic [RW-1:0] REM_INIT = RW'(FLUSH_SLOTS - 1);

    state_t        st_q, st_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          lu;
    logic          br_acc;

    assign state = st_q;

    assign lu = ex_mem_read & (ex_rd != '0) &
                ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        st_d         = st_q;
        rem_d        = rem_q;
        br_acc       = 1'b0;

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            st_d         = RUN;
        end else begin
            case (st_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        br_acc       = 1'b1;
                        if (FLUSH_SLOTS > 1) begin
                            st_d  = FLUSH;
                            rem_d = REM_INIT;
                        end
                    end else if (lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (mc_start) begin
                        // the multicycle op itself moves on into EX
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        st_d        = MC_WAIT;
                    end
                end
                MC_WAIT: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (mc_done) begin
                        st_d = RUN;
                    end
                end
                FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (ex_branch_taken) begin
                        br_acc = 1'b1;
                        rem_d  = REM_INIT;
                    end else begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q <= RW'(1)) begin
                            st_d = RUN;
                        end
                    end
                end
                default: begin
                    // unreachable encoding: hold everything for one cycle
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    st_d         = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= RUN;
            rem_q       <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            st_q  <= st_d;
            rem_q <= rem_d;
            if (!pc_write && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
            if (br_acc && flush_count != '1) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances share stimulus
// (default, FLUSH_SLOTS=3, CNT_W=4); each section checks the relevant one.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken;
    logic       mc_start, mc_done;

    logic        pw_a, iw_a, fl_a, bb_a;
    logic [15:0] sc_a, fc_a;
    logic [1:0]  st_a;
    logic        pw_b, iw_b, fl_b, bb_b;
    logic [15:0] sc_b, fc_b;
    logic [1:0]  st_b;
    logic        pw_c, iw_c, fl_c, bb_c;
    logic [3:0]  sc_c, fc_c;
    logic [1:0]  st_c;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mc_start(mc_start), .mc_done(mc_done),
        .pc_write(pw_a), .if_id_write(iw_a), .if_id_flush(fl_a),
        .id_ex_bubble(bb_a), .stall_count(sc_a),
        .flush_count(fc_a), .state(st_a)
    );

    pipeline_hazard_ctrl #(.FLUSH_SLOTS(3)) u_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mc_start(mc_start), .mc_done(mc_done),
        .pc_write(pw_b), .if_id_write(iw_b), .if_id_flush(fl_b),
        .id_ex_bubble(bb_b), .stall_count(sc_b),
        .flush_count(fc_b), .state(st_b)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mc_start(mc_start), .mc_done(mc_done),
        .pc_write(pw_c), .if_id_write(iw_c), .if_id_flush(fl_c),
        .id_ex_bubble(bb_c), .stall_count(sc_c),
        .flush_count(fc_c), .state(st_c)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs           = '0;
        id_rt           = '0;
        ex_rd           = '0;
        id_uses_rt      = 1'b0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        mc_start        = 1'b0;
        mc_done         = 1'b0;
    endtask

    // inputs change just after posedge; outputs sampled at negedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();

        // 1: reset forcing, then clean release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_pw", pw_a, 1'b0);
            chk("rst_fl", fl_a, 1'b1);
            chk("rst_bb", bb_a, 1'b1);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_st", st_a, 2'd0);
        chk("rel_sc", sc_a, 16'd0);
        chk("rel_fc", fc_a, 16'd0);
        chk("rel_pw", pw_a, 1'b1);

        // 2: load-use on rs
        tick();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs       = 5'd5;
        @(negedge clk);
        chk("lu_pw", pw_a, 1'b0);
        chk("lu_iw", iw_a, 1'b0);
        chk("lu_bb", bb_a, 1'b1);
        chk("lu_fl", fl_a, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("lu_resume", pw_a, 1'b1);
        chk("lu_sc", sc_a, 16'd1);
        tick();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd0;
        id_rs       = 5'd0;
        @(negedge clk);
        chk("lu_r0", pw_a, 1'b1);
        tick();
        ex_rd      = 5'd7;
        id_rt      = 5'd7;
        id_rs      = 5'd3;
        id_uses_rt = 1'b0;
        @(negedge clk);
        chk("lu_rt_unused", pw_a, 1'b1);
        tick();
        id_uses_rt = 1'b1;
        @(negedge clk);
        chk("lu_rt_used", pw_a, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("lu_sc2", sc_a, 16'd2);

        // 3: multicycle op, done arrives on 4th wait cycle
        do_reset();
        mc_start = 1'b1;
        mc_done  = 1'b1;
        @(negedge clk);
        chk("mc_iss_pw", pw_a, 1'b0);
        chk("mc_iss_bb", bb_a, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle();
            ex_branch_taken = (i == 1);
            mc_done         = (i == 3);
            @(negedge clk);
            chk("mc_w_st", st_a, 2'd1);
            chk("mc_w_pw", pw_a, 1'b0);
            chk("mc_w_bb", bb_a, 1'b1);
            chk("mc_w_fl", fl_a, 1'b0);
        end
        tick();
        idle();
        @(negedge clk);
        chk("mc_end_st", st_a, 2'd0);
        chk("mc_end_pw", pw_a, 1'b1);
        chk("mc_end_sc", sc_a, 16'd5);
        chk("mc_end_fc", fc_a, 16'd0);

        // 4: branch beats lu and mc_start (FLUSH_SLOTS=1)
        tick();
        ex_branch_taken = 1'b1;
        mc_start        = 1'b1;
        ex_mem_read     = 1'b1;
        ex_rd           = 5'd5;
        id_rs           = 5'd5;
        @(negedge clk);
        chk("br_fl", fl_a, 1'b1);
        chk("br_pw", pw_a, 1'b1);
        chk("br_iw", iw_a, 1'b1);
        chk("br_bb", bb_a, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("br_st", st_a, 2'd0);
        chk("br_fc", fc_a, 16'd1);
        chk("br_fl_off", fl_a, 1'b0);
        chk("br_sc", sc_a, 16'd5);

        // 5: FLUSH_SLOTS=3 squash, then extended squash
        do_reset();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("f3_c0_fl", fl_b, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            idle();
            @(negedge clk);
            chk("f3_fl", fl_b, 1'b1);
            chk("f3_st", st_b, 2'd2);
            chk("f3_pw", pw_b, 1'b1);
        end
        tick();
        @(negedge clk);
        chk("f3_done_fl", fl_b, 1'b0);
        chk("f3_done_st", st_b, 2'd0);
        chk("f3_fc1", fc_b, 16'd1);
        tick();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("f4_c0_fl", fl_b, 1'b1);
        tick();
        @(negedge clk);
        chk("f4_c1_fl", fl_b, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            idle();
            @(negedge clk);
            chk("f4_fl", fl_b, 1'b1);
            chk("f4_st", st_b, 2'd2);
        end
        tick();
        @(negedge clk);
        chk("f4_done_fl", fl_b, 1'b0);
        chk("f4_fc", fc_b, 16'd3);

        // 6: CNT_W=4 stall counter saturation, reset clears it
        do_reset();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs       = 5'd5;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            chk("sat_sc", sc_c, (i > 15) ? 32'd15 : 32'(i));
            chk("sat_pw", pw_c, 1'b0);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("sat_rst_pw", pw_c, 1'b0);
        chk("sat_rst_fl", fl_c, 1'b1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("sat_clr", sc_c, 4'd0);
        chk("sat_clr_st", st_c, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
